// File: rtl/sel_step_gen.sv
// Button-driven / auto-stepping 2-bit select generator for a 2-to-4 decoder stage.
// Raw buttons are synchronized, debounced, and turned into single press events.
`timescale 1ns/1ps

module sel_step_gen_deb #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_lvl,
  output logic o_press
);
  // state | meaning
  // IDLE  | released, stable 0
  // ARM   | candidate press, down-counting stable 1s
  // HELD  | pressed, stable 1
  // REL   | candidate release, down-counting stable 0s
  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

  localparam logic [15:0] LP_LOAD = 16'(DEBOUNCE_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (i_lvl) begin
        w_state_nxt = ARM;
        w_cnt_nxt   = LP_LOAD;
      end
      ARM: begin
        if (!i_lvl) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == 16'd0) begin
          w_state_nxt = HELD;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      HELD: if (!i_lvl) begin
        w_state_nxt = REL;
        w_cnt_nxt   = LP_LOAD;
      end
      REL: begin
        if (i_lvl) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == 16'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Press event fires only in the cycle that commits ARM->HELD.
  always_comb begin
    o_press = (r_state == ARM) && i_lvl && (r_cnt == 16'd0);
  end
endmodule

module sel_step_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_step,
  input  logic       i_btn_mode,
  input  logic       i_en,
  output logic [1:0] o_sel,
  output logic       o_step_pulse,
  output logic       o_auto_active
);
  localparam logic [23:0] LP_LAST = 24'(AUTO_PERIOD - 1);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic [1:0]  r_step_sync;
  logic [1:0]  r_mode_sync;
  logic        w_step_press;
  logic        w_mode_press;
  logic        w_tick;
  logic        w_step;
  logic [1:0]  r_sel;
  logic        r_pulse;
  logic        r_auto;
  logic [23:0] r_timer;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Synchronizers run on the raw reset so a held button is sampled while the
  // rest of the block is still coming out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_sync <= 2'b00;
      r_mode_sync <= 2'b00;
    end else begin
      r_step_sync <= {r_step_sync[0], i_btn_step};
      r_mode_sync <= {r_mode_sync[0], i_btn_mode};
    end
  end

  sel_step_gen_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_lvl   (r_step_sync[1]),
    .o_press (w_step_press)
  );

  sel_step_gen_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_lvl   (r_mode_sync[1]),
    .o_press (w_mode_press)
  );

  assign w_tick = r_auto && i_en && (r_timer == LP_LAST);
  assign w_step = i_en && (w_step_press || w_tick);

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sel   <= 2'b00;
      r_pulse <= 1'b0;
    end else begin
      if (w_step) r_sel <= r_sel + 2'd1;
      r_pulse <= w_step;
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_auto  <= 1'b0;
      r_timer <= '0;
    end else if (w_mode_press) begin
      r_auto  <= ~r_auto;
      r_timer <= '0;
    end else if (!r_auto) begin
      r_timer <= '0;
    end else if (i_en) begin
      r_timer <= w_tick ? 24'd0 : r_timer + 24'd1;
    end
  end

  assign o_sel         = r_sel;
  assign o_step_pulse  = r_pulse;
  assign o_auto_active = r_auto;
endmodule

// File: tb/tb_sel_step_gen.sv
// Self-checking bench for sel_step_gen: per-cycle comparison against a run-length
// debounce model plus directed latency, wrap, auto-tick, enable and reset checks.
`timescale 1ns/1ps

module tb_sel_step_gen;
  localparam int D = 4;
  localparam int P = 8;

  logic       clk;
  logic       rst_n;
  logic       btn_step;
  logic       btn_mode;
  logic       en;
  logic [1:0] o_sel;
  logic       o_step_pulse;
  logic       o_auto_active;

  int n_checks = 0;
  int n_pass   = 0;

  sel_step_gen #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_btn_step    (btn_step),
    .i_btn_mode    (btn_mode),
    .i_en          (en),
    .o_sel         (o_sel),
    .o_step_pulse  (o_step_pulse),
    .o_auto_active (o_auto_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a button's debounced level flips once D+2 consecutive raw
  // samples disagree with it; the resulting press acts on SEL two edges later.
  logic [1:0] m_sel;
  bit         m_pulse, m_auto;
  int         m_timer;
  bit         lvl_s, lvl_m;
  int         run_s, run_m;
  bit [1:0]   ps, pm;
  bit         ap_s, ap_m, tk, inc, det;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel = 2'd0; m_pulse = 0; m_auto = 0; m_timer = 0;
      lvl_s = 0; lvl_m = 0; run_s = 0; run_m = 0; ps = 0; pm = 0;
    end else begin
      ap_s = ps[1];
      ap_m = pm[1];
      tk  = m_auto && en && (m_timer == P - 1);
      inc = en && (ap_s || tk);
      if (inc) m_sel = m_sel + 2'd1;
      m_pulse = inc;
      if (ap_m) begin
        m_auto  = !m_auto;
        m_timer = 0;
      end else if (!m_auto) m_timer = 0;
      else if (en) m_timer = tk ? 0 : m_timer + 1;
      ps[1] = ps[0];
      pm[1] = pm[0];
      det = 0;
      if (btn_step == lvl_s) run_s = 0;
      else begin
        run_s++;
        if (run_s == D + 2) begin lvl_s = btn_step; run_s = 0; det = btn_step; end
      end
      ps[0] = det;
      det = 0;
      if (btn_mode == lvl_m) run_m = 0;
      else begin
        run_m++;
        if (run_m == D + 2) begin lvl_m = btn_mode; run_m = 0; det = btn_mode; end
      end
      pm[0] = det;
    end
  end

  task automatic test_reset();
    rst_n = 0; btn_step = 0; btn_mode = 0; en = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_sel, o_step_pulse, o_auto_active} !== 4'b0000)
      $display("FAIL reset_state dut=%b exp=0000", {o_sel, o_step_pulse, o_auto_active});
    else n_pass++;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL reset_idle cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
    end
  endtask

  task automatic test_clean_step();
    int lat = -1, pulses = 0;
    btn_step = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL clean_step cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse) begin pulses++; if (lat < 0) lat = i - 1; end
      if (i == 20) btn_step = 0;
    end
    n_checks++;
    if (lat !== 7) $display("FAIL clean_latency got=%0d exp=7", lat); else n_pass++;
    n_checks++;
    if (pulses !== 1 || o_sel !== 2'd1) $display("FAIL clean_once pulses=%0d sel=%0d exp=1/1", pulses, o_sel);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int bounce_pulses = 0, pulses = 0;
    logic [1:0] s0;
    s0 = o_sel;
    for (int i = 0; i < 45; i++) begin
      if (i < 20) btn_step = ((i / 2) % 2) == 0;
      else btn_step = (i < 32);
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL bounce cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse) begin pulses++; if (i < 22) bounce_pulses++; end
    end
    n_checks++;
    if (bounce_pulses !== 0 || pulses !== 1 || o_sel !== s0 + 2'd1)
      $display("FAIL bounce_events bounce=%0d total=%0d sel=%0d exp=0/1/%0d", bounce_pulses, pulses, o_sel, s0 + 2'd1);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [1:0] got [4];
    logic [1:0] exp_seq [4];
    int np = 0;
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 0; btn_step = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) begin
        btn_step = (i < 10);
        @(negedge clk);
        n_checks++;
        if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
          $display("FAIL wrap cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
        else n_pass++;
        if (o_step_pulse) begin if (np < 4) got[np] = o_sel; np++; end
      end
    end
    n_checks++;
    if (np !== 4) $display("FAIL wrap_pulses got=%0d exp=4", np); else n_pass++;
    for (int p = 0; p < 4 && p < np; p++) begin
      n_checks++;
      if (got[p] !== exp_seq[p]) $display("FAIL wrap_seq idx=%0d got=%0d exp=%0d", p, got[p], exp_seq[p]);
      else n_pass++;
    end
  endtask

  // Waits (bounded) for the next SEL pulse, comparing against the model meanwhile.
  task automatic test_auto();
    int t_a = -1, t_b = -1, pulses = 0;
    logic [1:0] s0;
    for (int i = 0; i < 20; i++) begin
      btn_mode = (i < 10);
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL auto_mode cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
    end
    n_checks++;
    if (o_auto_active !== 1'b1) $display("FAIL auto_on got=%b exp=1", o_auto_active); else n_pass++;
    for (int i = 0; i < 30 && t_b < 0; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL auto_tick cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse) begin if (t_a < 0) t_a = i; else t_b = i; end
    end
    n_checks++;
    if (t_b - t_a !== 8) $display("FAIL auto_period got=%0d exp=8", t_b - t_a); else n_pass++;
    // Just after a tick: a press sampled now debounces onto the next tick.
    s0 = o_sel;
    btn_step = 1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL auto_coincide cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse) pulses++;
      if (i == 8) begin
        n_checks++;
        if (o_sel !== s0 + 2'd1 || o_step_pulse !== 1'b1)
          $display("FAIL coincide_single sel=%0d pulse=%b exp=%0d/1", o_sel, o_step_pulse, s0 + 2'd1);
        else n_pass++;
      end
      if (i == 10) btn_step = 0;
    end
    n_checks++;
    if (pulses !== 2 || o_sel !== s0 + 2'd2) $display("FAIL coincide_next pulses=%0d sel=%0d exp=2/%0d", pulses, o_sel, s0 + 2'd2);
    else n_pass++;
  endtask

  task automatic test_enable();
    int synced = 0, bad = 0, lat = -1;
    logic [1:0] s0;
    for (int i = 0; i < 20 && synced == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL en_sync cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse) synced = 1;
    end
    n_checks++;
    if (synced !== 1) $display("FAIL en_sync_timeout got=%0d exp=1", synced); else n_pass++;
    s0 = o_sel;
    en = 0;
    for (int i = 1; i <= 20; i++) begin
      btn_step = (i >= 2 && i < 12);
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL en_hold cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_sel !== s0 || o_step_pulse !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL en_frozen bad_cycles=%0d exp=0", bad); else n_pass++;
    en = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL en_resume cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse && lat < 0) lat = i;
    end
    n_checks++;
    if (lat !== 8) $display("FAIL en_resume_tick got=%0d exp=8", lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int found = 0, lat = -1, pulses = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL rstmid_seek cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse && o_sel == 2'd3) found = 1;
    end
    n_checks++;
    if (found !== 1) $display("FAIL rstmid_sel3_timeout got=%0d exp=1", found); else n_pass++;
    btn_step = 1;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({o_sel, o_step_pulse, o_auto_active} !== 4'b0000)
      $display("FAIL rstmid_immediate dut=%b exp=0000", {o_sel, o_step_pulse, o_auto_active});
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL rstmid_after cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
      if (o_step_pulse) begin pulses++; if (lat < 0) lat = i - 1; end
    end
    n_checks++;
    if (lat !== 7 || pulses !== 1 || o_sel !== 2'd1)
      $display("FAIL rstmid_fresh lat=%0d pulses=%0d sel=%0d exp=7/1/1", lat, pulses, o_sel);
    else n_pass++;
    btn_step = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
      en = ($urandom_range(0, 99) < 85);
      @(negedge clk);
      n_checks++;
      if ({o_sel, o_step_pulse, o_auto_active} !== {m_sel, m_pulse, m_auto})
        $display("FAIL random cyc=%0d dut=%b model=%b", i, {o_sel, o_step_pulse, o_auto_active}, {m_sel, m_pulse, m_auto});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_wrap();
    test_auto();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
